// File: rtl/controle_pkg.sv
// Shared opcodes, state codes and datapath select encodings
// for the multicycle control unit.
package controle_pkg;

  typedef enum logic [5:0] {
    OP_ADD   = 6'h00,
    OP_SUB   = 6'h02,
    OP_AND   = 6'h03,
    OP_XOR   = 6'h04,
    OP_NOP   = 6'h05,
    OP_BREAK = 6'h07,
    OP_BEQ   = 6'h08,
    OP_J     = 6'h09,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcodeT;

  localparam logic [3:0] ST_RST     = 4'h0;
  localparam logic [3:0] ST_FETCH   = 4'h1;
  localparam logic [3:0] ST_FETCH_W = 4'h2;
  localparam logic [3:0] ST_DECODE  = 4'h3;
  localparam logic [3:0] ST_EXEC_R  = 4'h4;
  localparam logic [3:0] ST_WB_R    = 4'h5;
  localparam logic [3:0] ST_MEM_ADR = 4'h6;
  localparam logic [3:0] ST_MEM_RD  = 4'h7;
  localparam logic [3:0] ST_MEM_WB  = 4'h8;
  localparam logic [3:0] ST_MEM_WR  = 4'h9;
  localparam logic [3:0] ST_BRANCH  = 4'hA;
  localparam logic [3:0] ST_JUMP    = 4'hB;
  localparam logic [3:0] ST_HALT    = 4'hC;
  localparam logic [3:0] ST_ILLEGAL = 4'hD;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/contador_espera.sv
// Loadable down-counter with zero flag; paces memory read waits.
module contador_espera #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] loadVal,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= loadVal;
    else if (dec && !zero)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/unidade_controle.sv
// Multicycle Moore control unit driving the datapath selects.
// Optional trap on undefined opcodes: CTRL_ILLEGAL_TRAP_EN.
module unidade_controle
  import controle_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSourceA,
  output logic [1:0] AluSourceB,
  output logic [2:0] AluSel,
  output logic [1:0] PCSource,
  output logic       Halted,
  output logic [3:0] State
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       Illegal
`endif
);

  logic [3:0] state;
  logic [3:0] nextState;
  logic       cntZero;
  logic       cntLoad;
  logic       cntDec;
  // Zero only qualifies PCWriteCond inside the datapath
  logic       unusedZero;

  assign unusedZero = Zero;
  assign cntLoad = (state == ST_FETCH) || (state == ST_MEM_ADR);
  assign cntDec  = (state == ST_FETCH_W) || (state == ST_MEM_RD);

  contador_espera #(
    .W(4)
  ) uEspera (
    .clk    (Clk),
    .reset  (Reset),
    .load   (cntLoad),
    .dec    (cntDec),
    .loadVal(4'(MEM_WAIT_CYCLES - 1)),
    .zero   (cntZero)
  );

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= ST_RST;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_RST:     nextState = ST_FETCH;
      ST_FETCH:   nextState = ST_FETCH_W;
      ST_FETCH_W: if (cntZero) nextState = ST_DECODE;
      ST_DECODE: begin
        unique case (Opcode)
          OP_ADD, OP_SUB,
          OP_AND, OP_XOR: nextState = ST_EXEC_R;
          OP_LW, OP_SW:   nextState = ST_MEM_ADR;
          OP_BEQ:         nextState = ST_BRANCH;
          OP_J:           nextState = ST_JUMP;
          OP_NOP:         nextState = ST_FETCH;
          OP_BREAK:       nextState = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:        nextState = ST_ILLEGAL;
`else
          default:        nextState = ST_FETCH;
`endif
        endcase
      end
      ST_EXEC_R:  nextState = ST_WB_R;
      ST_MEM_ADR:
        nextState = (Opcode == OP_LW) ? ST_MEM_RD
                                      : ST_MEM_WR;
      ST_MEM_RD:  if (cntZero) nextState = ST_MEM_WB;
      ST_WB_R, ST_MEM_WB, ST_MEM_WR,
      ST_BRANCH, ST_JUMP:
        nextState = ST_FETCH;
      ST_HALT:    nextState = ST_HALT;
      ST_ILLEGAL: nextState = ST_ILLEGAL;
      default:    nextState = ST_RST;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSourceA  = 1'b0;
    AluSourceB  = SRCB_REGB;
    AluSel      = 3'b000;
    PCSource    = PCS_ALU;
    Halted      = 1'b0;
    unique case (state)
      ST_FETCH: MemRead = 1'b1;
      ST_FETCH_W: begin
        MemRead = 1'b1;
        if (cntZero) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          AluSourceB = SRCB_FOUR;
          AluSel     = ALU_ADD;
        end
      end
      // Branch target goes to ALUOut ahead of BRANCH
      ST_DECODE: begin
        AluSourceB = SRCB_IMM4;
        AluSel     = ALU_ADD;
      end
      ST_EXEC_R: begin
        AluSourceA = 1'b1;
        unique case (Opcode)
          OP_SUB:  AluSel = ALU_SUB;
          OP_AND:  AluSel = ALU_AND;
          OP_XOR:  AluSel = ALU_XOR;
          default: AluSel = ALU_ADD;
        endcase
      end
      ST_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      ST_MEM_ADR: begin
        AluSourceA = 1'b1;
        AluSourceB = SRCB_IMM;
        AluSel     = ALU_ADD;
      end
      ST_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      ST_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      ST_BRANCH: begin
        AluSourceA  = 1'b1;
        AluSel      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      ST_HALT, ST_ILLEGAL: Halted = 1'b1;
      default: ;
    endcase
  end

  assign State = state;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign Illegal = (state == ST_ILLEGAL);
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: one instance with 1 wait
// cycle, one with 3; both share Reset and Opcode.
module tb_unidade_controle;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluSel;
    logic [1:0] pcSource;
    logic       halted;
  } ctlT;

  // seq: one hex digit per cycle, the state expected at each
  // sample: 0 RST 1 FETCH 2 FETCH_W 3 DECODE 4 EXEC_R 5 WB_R
  // 6 MEM_ADDR 7 MEM_RD 8 MEM_WB 9 MEM_WR a BRANCH b JUMP
  // c HALT d ILLEGAL
  typedef struct {
    string      name;
    logic [5:0] op;
    bit         slow;
    string      seq;
  } vecT;

  logic       clk = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic       Zero;

  logic       pw1, pwc1, iod1, mr1, mw1, irw1, m2r1, rd1, rw1, sa1, h1;
  logic [1:0] sb1, pcs1;
  logic [2:0] as1;
  logic [3:0] st1;
  logic       pw3, pwc3, iod3, mr3, mw3, irw3, m2r3, rd3, rw3, sa3, h3;
  logic [1:0] sb3, pcs3;
  logic [2:0] as3;
  logic [3:0] st3;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       ill1, ill3;
`endif

  ctlT ctl1, ctl3;
  bit  slowSel;
  int  nChecks = 0;
  int  nFail = 0;
  vecT vt[14];

  always #5 clk = ~clk;

  unidade_controle #(.MEM_WAIT_CYCLES(1)) dut1 (
    .Clk(clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .PCWrite(pw1), .PCWriteCond(pwc1), .IorD(iod1),
    .MemRead(mr1), .MemWrite(mw1), .IRWrite(irw1),
    .MemToReg(m2r1), .RegDst(rd1), .RegWrite(rw1),
    .AluSourceA(sa1), .AluSourceB(sb1), .AluSel(as1),
    .PCSource(pcs1), .Halted(h1), .State(st1)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .Illegal(ill1)
`endif
  );

  unidade_controle #(.MEM_WAIT_CYCLES(3)) dut3 (
    .Clk(clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .PCWrite(pw3), .PCWriteCond(pwc3), .IorD(iod3),
    .MemRead(mr3), .MemWrite(mw3), .IRWrite(irw3),
    .MemToReg(m2r3), .RegDst(rd3), .RegWrite(rw3),
    .AluSourceA(sa3), .AluSourceB(sb3), .AluSel(as3),
    .PCSource(pcs3), .Halted(h3), .State(st3)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .Illegal(ill3)
`endif
  );

  assign ctl1 = {pw1, pwc1, iod1, mr1, mw1, irw1, m2r1, rd1,
                 rw1, sa1, sb1, as1, pcs1, h1};
  assign ctl3 = {pw3, pwc3, iod3, mr3, mw3, irw3, m2r3, rd3,
                 rw3, sa3, sb3, as3, pcs3, h3};

  function automatic logic [3:0] hexSt(input byte c);
    if (c >= "a") return 4'(c - "a" + 10);
    return 4'(c - "0");
  endfunction

  // Expected outputs per state, written from the control table
  function automatic ctlT expCtl(input logic [3:0] st,
                                 input logic [5:0] op,
                                 input bit lastWait);
    ctlT e;
    e = '0;
    case (st)
      4'h1: e.memRead = 1'b1;
      4'h2: begin
        e.memRead = 1'b1;
        if (lastWait) begin
          e.irWrite = 1'b1;
          e.pcWrite = 1'b1;
          e.aluSrcB = 2'b01;
          e.aluSel  = 3'b001;
        end
      end
      4'h3: begin e.aluSrcB = 2'b11; e.aluSel = 3'b001; end
      4'h4: begin
        e.aluSrcA = 1'b1;
        case (op)
          6'h02:   e.aluSel = 3'b010;
          6'h03:   e.aluSel = 3'b011;
          6'h04:   e.aluSel = 3'b110;
          default: e.aluSel = 3'b001;
        endcase
      end
      4'h5: begin e.regDst = 1'b1; e.regWrite = 1'b1; end
      4'h6: begin
        e.aluSrcA = 1'b1;
        e.aluSrcB = 2'b10;
        e.aluSel  = 3'b001;
      end
      4'h7: begin e.iorD = 1'b1; e.memRead = 1'b1; end
      4'h8: begin e.regWrite = 1'b1; e.memToReg = 1'b1; end
      4'h9: begin e.iorD = 1'b1; e.memWrite = 1'b1; end
      4'ha: begin
        e.aluSrcA     = 1'b1;
        e.aluSel      = 3'b010;
        e.pcWriteCond = 1'b1;
        e.pcSource    = 2'b01;
      end
      4'hb: begin e.pcWrite = 1'b1; e.pcSource = 2'b10; end
      4'hc, 4'hd: e.halted = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [3:0] st,
                       input ctlT e);
    ctlT g;
    logic [3:0] gs;
    logic gi, ei;
    g  = slowSel ? ctl3 : ctl1;
    gs = slowSel ? st3 : st1;
    ei = (st == 4'hd);
    gi = ei;
`ifdef CTRL_ILLEGAL_TRAP_EN
    gi = slowSel ? ill3 : ill1;
`endif
    nChecks++;
    if (gs !== st || g !== e || gi !== ei) begin
      nFail++;
      $display("FAIL %s: state=%h ctl=%h ill=%b, want state=%h ctl=%h ill=%b",
               name, gs, g, gi, st, e, ei);
    end
  endtask

  task automatic startInstr(input logic [5:0] op);
    @(negedge clk);
    Reset  = 1'b1;
    Opcode = op;
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic runVec(input vecT v);
    logic [3:0] st;
    bit last;
    int irw;
    slowSel = v.slow;
    irw = 0;
    startInstr(v.op);
    for (int i = 0; i < v.seq.len(); i++) begin
      st   = hexSt(v.seq[i]);
      last = (i + 1 >= v.seq.len()) || (v.seq[i+1] != "2");
      if (slowSel ? irw3 : irw1) irw++;
      check(v.name, st, expCtl(st, v.op, last));
      if (i + 1 < v.seq.len()) @(negedge clk);
    end
    nChecks++;
    if (irw != 1) begin
      nFail++;
      $display("FAIL %s irWritePulses: got %0d want 1", v.name, irw);
    end
  endtask

  initial begin
    Reset   = 1'b1;
    Opcode  = 6'h00;
    Zero    = 1'b0;
    slowSel = 1'b0;

    vt[0]  = '{"add",     6'h00, 1'b0, "0123451"};
    vt[1]  = '{"sub",     6'h02, 1'b0, "0123451"};
    vt[2]  = '{"and",     6'h03, 1'b0, "0123451"};
    vt[3]  = '{"xor",     6'h04, 1'b0, "0123451"};
    vt[4]  = '{"lw",      6'h23, 1'b0, "01236781"};
    vt[5]  = '{"sw",      6'h2B, 1'b0, "0123691"};
    vt[6]  = '{"beq",     6'h08, 1'b0, "0123a1"};
    vt[7]  = '{"j",       6'h09, 1'b0, "0123b1"};
    vt[8]  = '{"nop",     6'h05, 1'b0, "01231"};
    vt[9]  = '{"break",   6'h07, 1'b0, "0123ccc"};
`ifdef CTRL_ILLEGAL_TRAP_EN
    vt[10] = '{"undef",   6'h3F, 1'b0, "0123dddd"};
`else
    vt[10] = '{"undef",   6'h3F, 1'b0, "01231"};
`endif
    vt[11] = '{"lwSlow",  6'h23, 1'b1, "012223677781"};
    vt[12] = '{"addSlow", 6'h00, 1'b1, "012223451"};
    vt[13] = '{"swSlow",  6'h2B, 1'b1, "012223691"};

    // Reset held three cycles: everything quiet
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("resetHold", 4'h0, '0);
    end
    Reset = 1'b0;
    @(negedge clk);
    check("rel1", 4'h1, expCtl(4'h1, 6'h00, 1'b0));
    @(negedge clk);
    check("rel2", 4'h2, expCtl(4'h2, 6'h00, 1'b1));

    foreach (vt[k]) runVec(vt[k]);

    // HALT holds for 20 cycles, then Reset clears it in one edge
    slowSel = 1'b0;
    startInstr(6'h07);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check("haltHold", 4'hc, expCtl(4'hc, 6'h07, 1'b0));
      @(negedge clk);
    end
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check("haltReset", 4'h0, '0);
    @(negedge clk);
    check("haltToFetch", 4'h1, expCtl(4'h1, 6'h07, 1'b0));

    // Reset in the middle of a 3-cycle MEM_RD
    slowSel = 1'b1;
    startInstr(6'h23);
    repeat (8) @(negedge clk);
    check("midMemRd", 4'h7, expCtl(4'h7, 6'h23, 1'b0));
    Reset = 1'b1;
    @(negedge clk);
    check("memRdReset", 4'h0, '0);
    @(negedge clk);
    check("memRdResetHold", 4'h0, '0);
    Reset = 1'b0;
    @(negedge clk);
    check("memRdRelease", 4'h1, expCtl(4'h1, 6'h23, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
